// File: rtl/clkgate_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : clkgate_ctrl_if
// Brief    : Signal bundle between the clock-gate enable controller and its
//            surroundings (activity/request inputs, gating-cell pins, status).
// Revision : 1.0
// ============================================================================
interface clkgate_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             active;
  logic             req;
  logic             force_on;
  logic             se_in;
  logic             e;
  logic             se;
  logic             ack;
  logic             gated;
  logic [CNT_W-1:0] gate_cnt;

  // Environment side: drives activity/requests, observes the gating pins.
  modport master (
    output active, req, force_on, se_in,
    input  e, se, ack, gated, gate_cnt
  );

  // Controller side.
  modport slave (
    input  active, req, force_on, se_in,
    output e, se, ack, gated, gate_cnt
  );
endinterface
`default_nettype wire

// File: rtl/clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clkgate_ctrl
// Brief    : Enable controller for a test-enabled ICG cell. Stops the gated
//            clock after IDLE_CYCLES+1 idle edges, restarts it on request and
//            acknowledges once WAKE_CYCLES settle edges have elapsed. Keeps a
//            saturating count of entries into the gated state.
// Revision : 1.0
// ============================================================================
module clkgate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int WAKE_W      = 4,
  parameter int CNT_W       = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  clkgate_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_COUNT = 2'd1,
    S_GATED = 2'd2,
    S_WAKE  = 2'd3
  } state_t;

  // Counter reload values: the count runs down to zero inclusive.
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  state_t             state;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [WAKE_W-1:0]  wake_cnt;
  logic               e;
  logic               ack;
  logic               gated;
  logic [CNT_W-1:0]   gate_cnt;

  // Keep-alive sources seen while the clock runs; ACTIVE is meaningless once
  // the block's clock is stopped, so GATED only looks at req/force_on.
  logic busy;
  logic wake_req;
  assign busy     = bus.active | bus.req | bus.force_on;
  assign wake_req = bus.req | bus.force_on;

  // Scan enable goes straight to the cell; it never influences the FSM.
  assign bus.se       = bus.se_in;
  assign bus.e        = e;
  assign bus.ack      = ack;
  assign bus.gated    = gated;
  assign bus.gate_cnt = gate_cnt;

  // Idle/wake state machine with registered gating-cell and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      idle_cnt <= '0;
      wake_cnt <= '0;
      e        <= 1'b1;
      ack      <= 1'b1;
      gated    <= 1'b0;
      gate_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (!busy) begin
            state    <= S_COUNT;
            idle_cnt <= IDLE_LOAD;
          end
        end
        S_COUNT: begin
          // Activity wins over expiry on the same edge.
          if (busy) begin
            state <= S_RUN;
          end else if (idle_cnt == '0) begin
            state <= S_GATED;
            e     <= 1'b0;
            ack   <= 1'b0;
            gated <= 1'b1;
            if (gate_cnt != '1) begin
              gate_cnt <= gate_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        S_GATED: begin
          if (wake_req) begin
            state    <= S_WAKE;
            e        <= 1'b1;
            gated    <= 1'b0;
            wake_cnt <= WAKE_LOAD;
          end
        end
        S_WAKE: begin
          // Completes even if the request has since dropped.
          if (wake_cnt == '0) begin
            state <= S_RUN;
            ack   <= 1'b1;
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_RUN;
          e     <= 1'b1;
          ack   <= 1'b1;
          gated <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clkgate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkgate_ctrl
// Brief    : Self-checking bench for clkgate_ctrl with a behavioural model
//            based on idle-streak counting, an ICG cell model, and a small
//            second instance for counter saturation.
// Revision : 1.0
// ============================================================================
module tb_clkgate_ctrl;

  localparam int N = 16;
  localparam int M = 2;
  localparam int SMALL_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  clkgate_ctrl_if #(.CNT_W(16)) bus ();
  clkgate_ctrl_if #(.CNT_W(4))  sbus ();

  clkgate_ctrl #(
    .IDLE_CYCLES(N), .IDLE_W(8), .WAKE_CYCLES(M), .WAKE_W(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  clkgate_ctrl #(
    .IDLE_CYCLES(1), .IDLE_W(2), .WAKE_CYCLES(1), .WAKE_W(2), .CNT_W(4)
  ) dut_small (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  // Gating cell: latch transparent while clk low, AND with clk.
  logic latch_en = 1'b1;
  logic gck;
  always @(clk or bus.e or bus.se) if (!clk) latch_en = bus.e | bus.se;
  assign gck = clk & latch_en;
  int gck_pulses = 0;
  always @(posedge gck) gck_pulses++;

  // Unknown control inputs are illegal outside WAKE (WAKE is e=1, ack=0).
  always @(posedge clk) begin
    if (!rst && !(bus.e === 1'b1 && bus.ack === 1'b0)) begin
      assert (!$isunknown({bus.active, bus.req, bus.force_on}))
        else $error("FAIL x_input active=%b req=%b force_on=%b",
                    bus.active, bus.req, bus.force_on);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: gated flag, edges left until ack, length of current
  // idle streak, number of gating events.
  bit m_gated;
  int m_wake;
  int m_idle;
  int m_cnt;

  task automatic model_reset();
    m_gated = 1'b0;
    m_wake  = 0;
    m_idle  = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic a, input logic r, input logic f);
    if (m_gated) begin
      if (r | f) begin
        m_gated = 1'b0;
        m_wake  = M;
      end
    end else if (m_wake > 0) begin
      m_wake--;
      if (m_wake == 0) m_idle = 0;
    end else if (a | r | f) begin
      m_idle = 0;
    end else begin
      m_idle++;
      if (m_idle == N + 1) begin
        m_gated = 1'b1;
        m_idle  = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_e"},     32'(bus.e),        32'(!m_gated));
    check({pfx, "_ack"},   32'(bus.ack),      32'(!m_gated && m_wake == 0));
    check({pfx, "_gated"}, 32'(bus.gated),    32'(m_gated));
    check({pfx, "_cnt"},   32'(bus.gate_cnt), 32'(m_cnt));
    check({pfx, "_se"},    32'(bus.se),       32'(bus.se_in));
  endtask

  task automatic drive(input logic a, input logic r, input logic f, input logic s);
    bus.active   = a;
    bus.req      = r;
    bus.force_on = f;
    bus.se_in    = s;
  endtask

  // One clock edge: model sees the inputs the DUT samples, then compare.
  task automatic step(input string pfx);
    @(posedge clk);
    model_step(bus.active, bus.req, bus.force_on);
    #1;
    check_outputs(pfx);
  endtask

  int snap;
  int cnt_before;

  initial begin
    drive(0, 0, 0, 0);
    sbus.active = 1'b0; sbus.req = 1'b0; sbus.force_on = 1'b0; sbus.se_in = 1'b0;

    // Reset
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_e", 32'(bus.e), 32'd1);
    check("rst_ack", 32'(bus.ack), 32'd1);
    check("rst_gated", 32'(bus.gated), 32'd0);
    check("rst_cnt", 32'(bus.gate_cnt), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Idle gating latency
    for (int i = 0; i < N; i++) step("idle");
    check("pre_gate_e", 32'(bus.e), 32'd1);
    step("idle");
    check("gate_lat_e", 32'(bus.e), 32'd0);
    check("gate_lat_gated", 32'(bus.gated), 32'd1);
    check("gate_lat_cnt", 32'(bus.gate_cnt), 32'd1);
    snap = gck_pulses;
    for (int i = 0; i < 5; i++) step("gated");
    check("gck_stop", 32'(gck_pulses), 32'(snap));

    // Wake with a single-cycle request
    drive(0, 1, 0, 0);
    step("wake");
    drive(0, 0, 0, 0);
    check("wake_e", 32'(bus.e), 32'd1);
    check("wake_ack0", 32'(bus.ack), 32'd0);
    step("wake");
    check("wake_ack1", 32'(bus.ack), 32'd0);
    step("wake");
    check("wake_ack2", 32'(bus.ack), 32'd1);
    for (int i = 0; i < N; i++) step("rewait");
    check("regate_hold", 32'(bus.e), 32'd1);
    step("rewait");
    check("regate_e", 32'(bus.e), 32'd0);

    // Wake again, then interrupt the countdown at idle_cnt==3
    drive(0, 1, 0, 0);
    step("wake2");
    drive(0, 0, 0, 0);
    for (int i = 0; i < M; i++) step("wake2");
    for (int i = 0; i < 13; i++) step("intr");
    drive(1, 0, 0, 0);
    step("intr");
    drive(0, 0, 0, 0);
    check("intr_e", 32'(bus.e), 32'd1);
    for (int i = 0; i < N; i++) step("intr_hold");
    check("intr_hold_e", 32'(bus.e), 32'd1);
    step("intr_hold");
    check("intr_gate_e", 32'(bus.e), 32'd0);

    // Collision: request on the expiry edge
    drive(0, 1, 0, 0);
    step("wake3");
    drive(0, 0, 0, 0);
    for (int i = 0; i < M; i++) step("wake3");
    cnt_before = int'(bus.gate_cnt);
    for (int i = 0; i < N; i++) step("coll");
    drive(0, 1, 0, 0);
    step("coll");
    drive(0, 0, 0, 0);
    check("coll_e", 32'(bus.e), 32'd1);
    check("coll_gated", 32'(bus.gated), 32'd0);
    check("coll_cnt", 32'(bus.gate_cnt), 32'(cnt_before));

    // Scan in GATED
    for (int i = 0; i < N + 1; i++) step("toscan");
    drive(0, 0, 0, 1);
    @(negedge clk);
    snap = gck_pulses;
    for (int i = 0; i < 4; i++) step("scan");
    check("scan_se", 32'(bus.se), 32'd1);
    check("scan_e", 32'(bus.e), 32'd0);
    check("scan_ack", 32'(bus.ack), 32'd0);
    check("scan_gck", 32'(gck_pulses - snap), 32'd4);
    drive(0, 0, 0, 0);

    // Force on: wakes, then holds the clock for 10k cycles
    drive(0, 0, 1, 0);
    step("force");
    check("force_wake_e", 32'(bus.e), 32'd1);
    for (int i = 0; i < 10000; i++) step("force_hold");
    check("force_hold_gated", 32'(bus.gated), 32'd0);
    drive(0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) < 1, $urandom_range(0, 99) < 10);
      step("rand");
    end
    drive(0, 0, 0, 0);

    // Reset in the middle of WAKE
    for (int i = 0; i < 40 && !m_gated; i++) step("torst");
    check("torst_gated", 32'(bus.gated), 32'd1);
    drive(0, 1, 0, 0);
    step("rstwake");
    drive(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_e", 32'(bus.e), 32'd1);
    check("rst_mid_ack", 32'(bus.ack), 32'd1);
    check("rst_mid_gated", 32'(bus.gated), 32'd0);
    check("rst_mid_cnt", 32'(bus.gate_cnt), 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;

    // Saturation on the narrow-counter instance
    for (int ev = 1; ev <= 20; ev++) begin
      int w;
      w = 0;
      while (sbus.gated !== 1'b1 && w < 10) begin
        @(posedge clk); #1; w++;
      end
      check("sat_gate_seen", 32'(sbus.gated), 32'd1);
      check("sat_cnt", 32'(sbus.gate_cnt), 32'(ev < SMALL_MAX ? ev : SMALL_MAX));
      sbus.req = 1'b1;
      @(posedge clk); #1;
      sbus.req = 1'b0;
      w = 0;
      while (sbus.ack !== 1'b1 && w < 10) begin
        @(posedge clk); #1; w++;
      end
      check("sat_ack_seen", 32'(sbus.ack), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clkgate_ctrl.md
# clkgate_ctrl

Enable controller that drives the E and SE pins of a test-enabled integrated clock-gating cell (latch + AND, enable = E | SE). It watches activity from the gated block and stops the block's clock after a programmable idle interval. On a wake request it restarts the clock and raises an acknowledge only after a settle interval. It runs on the free-running clock, ahead of the gating cell, and also keeps a saturating count of gating events.

## Interface
- IDLE_CYCLES, 16: idle hysteresis length N, from 1 to 2^IDLE_W-1.
- IDLE_W, 8: width of the idle down-counter.
- WAKE_CYCLES, 2: settle interval M between E rising and ACK rising; M ≥ 1.
- WAKE_W, 4: width of the wake down-counter.
- CK  input  1  free-running clock (ungated); all state on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- ACTIVE  input  1  gated block busy; ignored in GATED and WAKE.
- REQ  input  1  wake / keep-alive request from the ungated domain.
- FORCE_ON  input  1  software override that holds the clock on.
- SE_IN  input  1  scan enable.
- E  output  1  registered enable to the gating cell E pin.
- SE  output  1  combinational, equals SE_IN.
- ACK  output  1  registered; 1 means the gated clock is running and stable.
- GATED  output  1  registered; 1 in the GATED state.
- GATE_CNT  output  16  registered; saturating count of entries into GATED.

## Operation
- States: RUN, COUNT, GATED, WAKE. Define busy = ACTIVE | REQ | FORCE_ON. In GATED, busy = REQ | FORCE_ON.
- Reset (asynchronous, takes effect immediately, including mid-WAKE or mid-COUNT):
  - state goes to RUN.
  - E=1, ACK=1, GATED=0, GATE_CNT=0, both counters 0.
- RUN: E=1, ACK=1.
  - If !busy: go to COUNT and load idle_cnt = N-1.
  - Otherwise stay in RUN.
- COUNT: E=1, ACK=1.
  - busy: go to RUN. Activity has priority over expiry when both occur on the same edge.
  - else if idle_cnt==0: go to GATED. E=0, ACK=0, GATED=1, and GATE_CNT increments (saturates at 0xFFFF).
  - else: decrement idle_cnt.
- GATED: E=0, ACK=0.
  - REQ|FORCE_ON: go to WAKE. E=1, load wake_cnt = M-1.
- WAKE: E=1, ACK=0.
  - If wake_cnt==0: go to RUN with ACK=1.
  - Otherwise decrement wake_cnt.
  - If REQ drops during WAKE, WAKE still completes to RUN. Idle detection then restarts from RUN.
- SE_IN does not affect the FSM or the counters. The gating cell ORs SE_IN, so the clock runs during scan regardless of E.
- X on REQ, ACTIVE or FORCE_ON during RUN, COUNT or GATED is a verification error. The bench must flag it with an assertion.

## Timing
- Gating latency: E falls on the (N+1)th consecutive rising edge that samples !busy. One edge is RUN→COUNT, N-1 edges decrement, one edge is COUNT→GATED.
- The gating cell latches E while CK is low. The last GCK high pulse is therefore the one in the cycle in which E falls. No GCK pulse occurs afterwards.
- Wake latency:
  - If REQ is sampled high at edge k in GATED, E=1 after edge k.
  - ACK=1 after edge k+M.
  - The first GCK pulse occurs in the cycle after edge k.
- A busy pulse of one cycle in COUNT fully restarts the N-cycle count.
- E, ACK, GATED and GATE_CNT change only on CK rising edges or on RST. SE tracks SE_IN combinationally.
- GATE_CNT updates on the same edge at which GATED rises.

## Test plan
- Reset, then hold all inputs low with N=16:
  - E, ACK and GATED are 1, 1 and 0 out of reset.
  - E falls after exactly 17 edges, GATED=1 and GATE_CNT=1.
  - GCK stops.
- Idle countdown interrupted: pulse ACTIVE high for one cycle when idle_cnt=3.
  - FSM returns to RUN and E stays 1.
  - E falls 17 edges after ACTIVE falls.
- Wake with M=2: assert REQ for one cycle while in GATED.
  - E=1 after the next edge.
  - ACK=1 exactly 2 edges later, even though REQ has dropped.
  - If inputs then stay idle, E falls again after 17 further edges.
- Collision: in COUNT with idle_cnt=0, raise REQ on the same edge.
  - State goes to RUN, E stays 1, GATE_CNT is unchanged.
- Scan and force:
  - With SE_IN=1 in GATED: SE=1 and GCK toggles, while E=0 and ACK=0.
  - Raising FORCE_ON in GATED wakes the block. FORCE_ON held high prevents gating indefinitely (10,000 cycles).
- Reset mid-WAKE, and saturation:
  - Assert RST mid-WAKE: E, ACK and GATED go to 1, 1 and 0 immediately (before the next edge) and GATE_CNT=0.
  - Force 65,536 gating events: GATE_CNT holds at 0xFFFF.
